// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: prescaled step tick drives an OFF/BLINK/CHASE/COUNT pattern.
// Optional PWM brightness control is compiled in with `define LED_PWM_EN (adds the duty port).
module led_pattern_gen #(
    parameter int unsigned PERIOD = 50_000_000,
    parameter int unsigned N_LED  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
`ifdef LED_PWM_EN
    input  logic [7:0]       duty,
`endif
    output logic [N_LED-1:0] led,
    output logic             tick
);

    localparam int unsigned CNT_W = $clog2(PERIOD);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } mode_t;

    logic [CNT_W-1:0] cnt;
    logic [N_LED-1:0] pattern;
    mode_t            mode_q;

    mode_t            mode_c;
    logic             last_cnt_c;
    logic [N_LED-1:0] pattern_init_c;
    logic [N_LED-1:0] pattern_step_c;

    assign mode_c     = mode_t'(mode);
    assign last_cnt_c = (cnt == CNT_W'(PERIOD - 1));

    // Reload value for a freshly selected mode and the next pattern for the current mode.
    always_comb begin
        pattern_init_c = '0;
        if (mode_c == MODE_CHASE) begin
            pattern_init_c = N_LED'(1);
        end

        pattern_step_c = pattern;
        case (mode_q)
            MODE_OFF:   pattern_step_c = '0;
            MODE_BLINK: pattern_step_c = ~pattern;
            MODE_CHASE: pattern_step_c = dir ? {pattern[0], pattern[N_LED-1:1]}
                                             : {pattern[N_LED-2:0], pattern[N_LED-1]};
            MODE_COUNT: pattern_step_c = pattern + N_LED'(1);
            default:    pattern_step_c = pattern;
        endcase
    end

    // A mode change reloads the pattern and restarts the prescaler, overriding any step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            pattern <= '0;
            mode_q  <= MODE_OFF;
            tick    <= 1'b0;
        end else if (mode_c != mode_q) begin
            mode_q  <= mode_c;
            cnt     <= '0;
            pattern <= pattern_init_c;
            tick    <= 1'b0;
        end else if (en) begin
            if (last_cnt_c) begin
                cnt     <= '0;
                pattern <= pattern_step_c;
                tick    <= 1'b1;
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;
    logic       pwm_on;

    // Free-running brightness counter; independent of en so dimming continues while frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pwm_on  <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            pwm_on  <= (pwm_cnt < duty);
        end
    end

    assign led = pattern & {N_LED{pwm_on}};
`else
    assign led = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen (PERIOD=4, N_LED=4): stimulus queues the led value
// expected at each tick, a monitor pops and compares whenever tick is seen.
module tb_led_pattern_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] mode;
    logic       dir;
    logic [3:0] led;
    logic       tick;
`ifdef LED_PWM_EN
    logic [7:0] duty;
    logic [7:0] mdl_cnt;
    logic       mdl_on;
`endif

    int         vectors;
    int         miscompares;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    led_pattern_gen #(
        .PERIOD(4),
        .N_LED (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .mode (mode),
        .dir  (dir),
`ifdef LED_PWM_EN
        .duty (duty),
`endif
        .led  (led),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Visible led value for a given pattern (PWM gate applied when compiled in).
    function automatic logic [3:0] vis(input logic [3:0] p);
`ifdef LED_PWM_EN
        return p & {4{mdl_on}};
`else
        return p;
`endif
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles until the next tick, bounded so a dead prescaler cannot hang the run.
    task automatic wait_one_tick(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!tick && cyc < 40);
    endtask

    initial begin
        int c;
        int nt;
        int hi[4];

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        dir   = 1'b0;
`ifdef LED_PWM_EN
        duty  = 8'd200;
`endif

        fork
            begin : stim
                wait_cyc(2);
                check("reset_led", 32'(led), 32'h0);
                check("reset_tick", 32'(tick), 32'h0);
                rst_n = 1'b1;
                wait_cyc(2);

                // CHASE left, then right from 0100
                mode = 2'd2;
                en   = 1'b1;
                exp_q.push_back(4'b0010);
                exp_q.push_back(4'b0100);
                exp_q.push_back(4'b1000);
                exp_q.push_back(4'b0001);
                exp_q.push_back(4'b0010);
                exp_q.push_back(4'b0100);
                wait_cyc(1);
                check("chase_init_led", 32'(led), 32'(vis(4'b0001)));
                check("chase_init_tick", 32'(tick), 32'h0);
                repeat (6) begin
                    wait_one_tick(c);
                    check("chase_gap", 32'(c), 32'd4);
                end
                dir = 1'b1;
                exp_q.push_back(4'b0010);
                exp_q.push_back(4'b0001);
                exp_q.push_back(4'b1000);
                repeat (3) begin
                    wait_one_tick(c);
                    check("chase_r_gap", 32'(c), 32'd4);
                end

                // Asynchronous reset in the middle of a tick cycle
                #2 rst_n = 1'b0;
                #1;
                check("async_rst_led", 32'(led), 32'h0);
                check("async_rst_tick", 32'(tick), 32'h0);
                wait_cyc(2);
                rst_n = 1'b1;
                wait_cyc(1);
                check("rst_release_led", 32'(led), 32'(vis(4'b0001)));
                check("rst_release_tick", 32'(tick), 32'h0);

                // COUNT: 16 ticks in 64 cycles, wrapping 1111 -> 0000
                mode = 2'd3;
                for (int i = 1; i <= 16; i++) exp_q.push_back(4'(i));
                exp_q.push_back(4'b0001);
                wait_cyc(1);
                check("count_init_led", 32'(led), 32'(vis(4'b0000)));
                nt = 0;
                repeat (64) begin
                    @(negedge clk);
                    nt += int'(tick);
                end
                check("count_ticks_64", 32'(nt), 32'd16);
                wait_cyc(6);

                // Freeze with cnt==2
                en = 1'b0;
                nt = 0;
                repeat (10) begin
                    @(negedge clk);
                    nt += int'(tick);
                end
                check("freeze_ticks", 32'(nt), 32'd0);
                check("freeze_led", 32'(led), 32'(vis(4'b0001)));
                en = 1'b1;
                exp_q.push_back(4'b0010);
                wait_one_tick(c);
                check("resume_gap", 32'(c), 32'd2);

                // Mode change on the same edge as cnt==3: reload wins
                wait_cyc(3);
                mode = 2'd1;
                wait_cyc(1);
                check("reload_led", 32'(led), 32'(vis(4'b0000)));
                check("reload_tick", 32'(tick), 32'h0);
                exp_q.push_back(4'b1111);
                wait_one_tick(c);
                check("reload_gap", 32'(c), 32'd4);
                exp_q.push_back(4'b0000);
                exp_q.push_back(4'b1111);
                exp_q.push_back(4'b0000);
                repeat (3) begin
                    wait_one_tick(c);
                    check("blink_gap", 32'(c), 32'd4);
                end

`ifdef LED_PWM_EN
                // Hold 1111 with the prescaler frozen and measure brightness
                exp_q.push_back(4'b1111);
                wait_one_tick(c);
                check("pwm_pre_gap", 32'(c), 32'd4);
                en   = 1'b0;
                duty = 8'd64;
                for (int b = 0; b < 4; b++) hi[b] = 0;
                repeat (256) begin
                    @(negedge clk);
                    for (int b = 0; b < 4; b++) hi[b] += int'(led[b]);
                end
                for (int b = 0; b < 4; b++) check("pwm_duty64_bit", 32'(hi[b]), 32'd64);
                duty = 8'd0;
                nt = 0;
                repeat (512) begin
                    @(negedge clk);
                    nt += int'(led != 4'b0000);
                end
                check("pwm_duty0_on", 32'(nt), 32'd0);
                duty = 8'd255;
                en   = 1'b1;
                exp_q.push_back(4'b0000);
                wait_one_tick(c);
                check("pwm_tick_gap", 32'(c), 32'd4);
`endif
                wait_cyc(2);
            end
            begin : mon
                forever begin
                    @(negedge clk);
                    if (rst_n && tick) begin
                        if (exp_q.size() == 0) begin
                            check("tick_unexpected", 32'(tick), 32'h0);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            check("tick_led", 32'(led), 32'(vis(mon_exp)));
                        end
                    end
                end
            end
`ifdef LED_PWM_EN
            begin : pwm_model
                forever begin
                    @(posedge clk or negedge rst_n);
                    if (!rst_n) begin
                        mdl_cnt = 8'd0;
                        mdl_on  = 1'b0;
                    end else begin
                        mdl_on  = (mdl_cnt < duty);
                        mdl_cnt = mdl_cnt + 8'd1;
                    end
                end
            end
`endif
        join_any
        disable fork;

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised, multi-channel LED pattern generator. It is the successor to the single-LED fixed-period blinker.
- A prescaler divides `clk` into a step tick.
- On each tick, an N_LED-wide pattern register advances according to a run-time mode: off, blink, chase or binary count.
- Sits between board clock/reset and the LED pins; mode, enable and direction come from user I/O or a control block.

Parameters:
- PERIOD, 50_000_000: clk cycles per pattern step (1 s at 50 MHz). Legal range ≥ 2. Prescaler width is $clog2(PERIOD).
- N_LED, 4: number of LED outputs. Legal range ≥ 2.

Ports:
- clk     in   1      system clock, all logic on rising edge
- rst_n   in   1      reset, asynchronous assert, active-low
- en      in   1      1 = prescaler runs; 0 = freeze prescaler and pattern
- mode    in   2      0 OFF, 1 BLINK, 2 CHASE, 3 COUNT
- dir     in   1      CHASE direction: 0 rotate left (toward MSB), 1 rotate right
- led     out  N_LED  LED drive, 1 = on
- tick    out  1      one-cycle pulse, high in the cycle the pattern advances

Behaviour:
- **Reset (rst_n=0, async):**
  - cnt=0, pattern=0, mode_q=OFF(0), tick=0.
  - led=0 (also the PWM counter=0 when compiled in).
- **Prescaler:**
  - When en=1, cnt increments each cycle.
  - When cnt==PERIOD-1 and en=1: cnt wraps to 0 and the tick event fires.
  - When en=0: cnt holds, no tick event.
- **tick output:** registered; high exactly one cycle, the cycle after cnt==PERIOD-1 was sampled with en=1. It is coincident with the new pattern appearing on led.
- **Mode change:**
  - At any edge where mode != mode_q: mode_q<=mode, cnt<=0, pattern<=init(mode).
  - init values: OFF 0, BLINK 0, CHASE one-hot bit0, COUNT 0.
  - led shows the init pattern 1 cycle after mode changes.
  - Mode reload takes priority over a simultaneous tick event. The pattern does not advance, tick stays 0, and en is ignored for the reload.
- **Step on tick event, by mode_q:**
  - OFF: pattern stays 0.
  - BLINK: pattern <= ~pattern (all LEDs toggle; 50% duty, full cycle = 2·PERIOD).
  - CHASE, dir=0: rotate left, MSB wraps to bit0.
  - CHASE, dir=1: rotate right, bit0 wraps to MSB.
  - dir is sampled per tick and may change at any time without reload.
  - COUNT: pattern <= pattern+1, modulo 2^N_LED (all-ones wraps to 0).
- **Output:** led = pattern (direct register output, no combinational path from inputs) when PWM is not compiled.
- **Reset mid-operation:** all state returns to reset values immediately. After release, the first edge reloads init(mode) if mode != OFF.

Optional Feature:
- Macro: LED_PWM_EN.
- **Defined:**
  - Adds input port `duty[7:0]`.
  - Adds a free-running 8-bit pwm_cnt (reset 0, wraps 255→0, runs regardless of en).
  - Adds register pwm_on <= (pwm_cnt < duty).
  - led = pattern & {N_LED{pwm_on}}.
  - Brightness results: duty=0 gives all off; duty=255 gives on 255/256 cycles.
  - tick timing is unchanged.
- **Undefined:** no duty port, no PWM logic; led = pattern.

Test Plan (PERIOD=4, N_LED=4):
1. Reset: assert rst_n=0 mid-run with en=1, mode=2 → led=0000 and tick=0 immediately (asynchronous). After release with mode=2, led=0001 one cycle later.
2. CHASE, en=1, dir=0: tick every 4 cycles, led sequence 0001→0010→0100→1000→0001. Switch dir=1 at 0100 → next 0010.
3. COUNT, en=1: led 0000→0001→…→1111→0000 over 16 ticks; tick pulses exactly 16 in 64 cycles.
4. en=0 for 10 cycles when cnt=2 → no tick, led frozen. en=1 → next tick 2 cycles later.
5. mode 3→1 on the same edge as cnt==3 → led=0000, tick=0, following tick 4 cycles later; BLINK then toggles led 0000↔1111 each tick.
6. LED_PWM_EN, mode=1 with led pattern 1111:
   - duty=64 → each led high exactly 64 of every 256 cycles.
   - duty=0 → led stays 0000 for 512 cycles.
   - tick period unchanged.
